fetch_stage: RTL

Instruction fetch stage with IF/ID pipeline register. It sits directly upstream of the opcode decoder/control unit and drives it with `opcode_o`, which is `instr_o[31:27]`. The block maintains the PC and issues requests to a synchronous instruction memory with 1-cycle read latency. It absorbs one in-flight word during stalls, and it flushes and redirects on taken branches.

---
 rtl/fetch_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, 1-cycle-latency imem requests,
// single-entry stall capture buffer and IF/ID pipeline register.
module fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [4:0]         opcode_o
);

    // Encoding is {inflight, hold_valid}; 2'b11 must never occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HELD  = 2'b01,
        FETCH = 2'b10
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    assign imem_en   = !rst && !branch_taken_i && !stall_i;
    assign imem_addr = pc;
    assign opcode_o  = instr_o[INSTR_W-1 -: 5];

    // NOTE: fetch_pc and the hold buffer are data-only registers qualified by
    // state, so they are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            pc      <= RESET_PC;
            valid_o <= 1'b0;
            instr_o <= '0;
            pc_o    <= '0;
        end else if (branch_taken_i) begin
            // Wrong-path word (in flight or held) is simply dropped.
            state   <= EMPTY;
            pc      <= branch_target_i;
            valid_o <= 1'b0;
            instr_o <= '0;
        end else if (stall_i) begin
            if (state == FETCH) begin
                hold_instr <= imem_rdata;
                hold_pc    <= fetch_pc;
                state      <= HELD;
            end
        end else begin
            case (state)
                HELD: begin
                    valid_o <= 1'b1;
                    instr_o <= hold_instr;
                    pc_o    <= hold_pc;
                end
                FETCH: begin
                    valid_o <= 1'b1;
                    instr_o <= imem_rdata;
                    pc_o    <= fetch_pc;
                end
                default: begin
                    valid_o <= 1'b0;
                    instr_o <= '0;
                end
            endcase
            fetch_pc <= pc;
            pc       <= pc + ADDR_W'(PC_STEP);
            state    <= FETCH;
        end
    end

    a_no_inflight_and_held : assert property (@(posedge clk) disable iff (rst)
        state != 2'b11);

endmodule
